complete_queue: RTL
===================

# complete_queue

Parametrised completion stage between the functional-unit result lanes and the ROB/physical-register-file write ports. Accepts up to NUM_IN results per cycle, compacts them into an in-order circular buffer, and drains up to NUM_OUT oldest entries per cycle into registered write-back outputs. Provides backpressure, a flush, and a sticky overflow flag. This absorbs bursts when more units finish than the ROB can retire-mark in one cycle.

## Interface
- NUM_IN, 3, number of FU result lanes
- NUM_OUT, 2, number of ROB/regfile completion ports
- DEPTH, 8, queue entries; power of two, DEPTH >= NUM_IN + NUM_OUT
- XLEN, 32, PC/data width
- PREG_W, 6, physical dest-register tag width
- ROB_W, 6, ROB index width

- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous, active-high reset (port keeps the codebase name; asserted = 1)
- flush  in  1  synchronous queue clear
- in_valid  in  NUM_IN  per-lane result valid
- in_pc  in  NUM_IN*XLEN  lane i at [i*XLEN +: XLEN]
- in_dr  in  NUM_IN*PREG_W  dest physical register
- in_data  in  NUM_IN*XLEN  dest register data
- in_rob  in  NUM_IN*ROB_W  ROB index
- in_ready  out  1  queue can accept a full NUM_IN-lane group this cycle
- out_valid  out  NUM_OUT  per-port completion valid
- out_pc, out_dr, out_data, out_rob  out  NUM_OUT*(XLEN|PREG_W|XLEN|ROB_W)  packed as inputs
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow_err  out  1  sticky: valid input presented while in_ready low

## Operation
- Storage: DEPTH entries {pc, dr, data, rob}; head/tail pointers of $clog2(DEPTH) bits, wrap modulo DEPTH.
- in_ready = (DEPTH - count) >= NUM_IN, combinational from registered count.
- Enqueue (in_ready=1, flush=0): valid lanes written in ascending lane index to tail, tail+1, ...; invalid lanes skipped (compaction). n_enq = popcount(in_valid).
- in_ready=0 with any in_valid: all lanes dropped, nothing written, overflow_err set; cleared only by reset.
- Dequeue: n_deq = min(count, NUM_OUT); out port j loaded from entry head+j for j < n_deq, out_valid[j]=1; remaining ports out_valid=0, payload holds last value.
- Occupancy: count_next = count + n_enq - n_deq; head += n_deq, tail += n_enq, both modulo DEPTH.
- Simultaneous enqueue and dequeue in same cycle allowed; dequeue sees only pre-edge occupancy (no bypass).
- dr = 0 passes through unchanged (downstream treats it as no register write).
- flush=1: next edge head=tail=0, count=0, out_valid=0, inputs ignored; overflow_err not set and not cleared by flush. Flush beats enqueue and dequeue.
- No downstream backpressure: ROB ports always accept.

## Timing
- Reset (asynchronous, immediate): head, tail, count = 0; out_valid = 0; all out payloads = 0; overflow_err = 0; in_ready = 1.
- Latency: result presented before edge k is written at edge k; visible on out_* after edge k+1 (2-cycle input-to-output).
- Throughput: NUM_OUT entries/cycle sustained; NUM_IN-lane bursts buffered.
- Ordering: output order = lane-index order within a cycle, then arrival cycle; never reordered.
- Reset asserted mid-stream discards all entries; first edge after deassert behaves as empty queue.

## Test plan
- Reset: rstn=1 mid-cycle -> all outputs 0, in_ready=1, count=0 immediately without clock.
- Single lane: edge0 in_valid=3'b010, pc=0x100, dr=5, data=0xDEADBEEF, rob=3 -> after edge1 out_valid=2'b01, port0={0x100,5,0xDEADBEEF,3}; count 1 then 0.
- Full burst: edge0 all 3 lanes, rob=10,11,12 -> after edge1 ports0/1 rob=10,11 valid=2'b11; after edge2 port0 rob=12, out_valid=2'b01.
- Saturation: 3 valid lanes every cycle -> count 3,4,5,6; at count=6 in_ready=0; next presented group dropped, overflow_err=1 and stays 1 after queue drains.
- Flush: count=5 with in_valid=3'b111 and flush=1 -> next edge count=0, out_valid=0, no inputs enqueued, overflow_err unchanged.
- Wrap: stream 20 entries with rob 0..19 in mixed lane patterns -> outputs emit rob 0..19 in order, pointers wrap twice, no loss.

Source files
------------

// File: rtl/complete_queue.sv
// complete_queue: completion buffer between the functional-unit result lanes
// and the ROB / physical register file write ports. Results that arrive in the
// same cycle are packed in lane order into a circular buffer. Up to NUM_OUT of
// the oldest entries leave each cycle through registered write-back ports.
// The reset port keeps its historical name "rstn" but is active-high and
// asynchronous: driving it to 1 clears the block at once.
module complete_queue #(
  parameter int NUM_IN  = 3,
  parameter int NUM_OUT = 2,
  parameter int DEPTH   = 8,
  parameter int XLEN    = 32,
  parameter int PREG_W  = 6,
  parameter int ROB_W   = 6
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
  input  logic [NUM_IN-1:0]         in_valid,
  input  logic [NUM_IN*XLEN-1:0]    in_pc,
  input  logic [NUM_IN*PREG_W-1:0]  in_dr,
  input  logic [NUM_IN*XLEN-1:0]    in_data,
  input  logic [NUM_IN*ROB_W-1:0]   in_rob,
  output logic                      in_ready,
  output logic [NUM_OUT-1:0]        out_valid,
  output logic [NUM_OUT*XLEN-1:0]   out_pc,
  output logic [NUM_OUT*PREG_W-1:0] out_dr,
  output logic [NUM_OUT*XLEN-1:0]   out_data,
  output logic [NUM_OUT*ROB_W-1:0]  out_rob,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] NUM_IN_C  = CNT_W'(NUM_IN);
  localparam logic [CNT_W-1:0] NUM_OUT_C = CNT_W'(NUM_OUT);

  // Buffer storage, one array per payload field
  logic [XLEN-1:0]   mem_pc_q   [DEPTH];
  logic [XLEN-1:0]   mem_pc_d   [DEPTH];
  logic [PREG_W-1:0] mem_dr_q   [DEPTH];
  logic [PREG_W-1:0] mem_dr_d   [DEPTH];
  logic [XLEN-1:0]   mem_data_q [DEPTH];
  logic [XLEN-1:0]   mem_data_d [DEPTH];
  logic [ROB_W-1:0]  mem_rob_q  [DEPTH];
  logic [ROB_W-1:0]  mem_rob_d  [DEPTH];

  // Pointers, occupancy and the sticky overflow flag
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  // Registered write-back ports
  logic [NUM_OUT-1:0]        out_valid_q, out_valid_d;
  logic [NUM_OUT*XLEN-1:0]   out_pc_q, out_pc_d;
  logic [NUM_OUT*PREG_W-1:0] out_dr_q, out_dr_d;
  logic [NUM_OUT*XLEN-1:0]   out_data_q, out_data_d;
  logic [NUM_OUT*ROB_W-1:0]  out_rob_q, out_rob_d;

  // Per-cycle bookkeeping
  logic [CNT_W-1:0] free_slots;
  logic             enq_accept;
  logic             enq_drop;
  logic [CNT_W-1:0] n_enq;
  logic [CNT_W-1:0] n_deq;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;

  // A group is accepted only when every lane could be valid, so the decision
  // never depends on how many lanes are actually valid this cycle
  always_comb begin
    free_slots = DEPTH_C - count_q;
    in_ready   = (free_slots >= NUM_IN_C);
    enq_accept = in_ready && !flush;
    enq_drop   = !in_ready && !flush && (|in_valid);
  end

  // Dequeue only sees entries present before the edge; there is no bypass
  always_comb begin
    n_deq = (count_q < NUM_OUT_C) ? count_q : NUM_OUT_C;
  end

  // Compact the valid lanes into consecutive slots starting at the tail
  always_comb begin
    mem_pc_d   = mem_pc_q;
    mem_dr_d   = mem_dr_q;
    mem_data_d = mem_data_q;
    mem_rob_d  = mem_rob_q;
    n_enq      = '0;
    wr_idx     = '0;
    if (enq_accept) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_valid[i]) begin
          wr_idx             = tail_q + PTR_W'(n_enq);
          mem_pc_d[wr_idx]   = in_pc[i*XLEN +: XLEN];
          mem_dr_d[wr_idx]   = in_dr[i*PREG_W +: PREG_W];
          mem_data_d[wr_idx] = in_data[i*XLEN +: XLEN];
          mem_rob_d[wr_idx]  = in_rob[i*ROB_W +: ROB_W];
          n_enq              = n_enq + 1'b1;
        end
      end
    end
  end

  // Load the oldest entries onto the ports; idle ports keep their old payload
  always_comb begin
    out_valid_d = '0;
    out_pc_d    = out_pc_q;
    out_dr_d    = out_dr_q;
    out_data_d  = out_data_q;
    out_rob_d   = out_rob_q;
    rd_idx      = '0;
    if (!flush) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (CNT_W'(j) < n_deq) begin
          rd_idx                          = head_q + PTR_W'(j);
          out_valid_d[j]                  = 1'b1;
          out_pc_d[j*XLEN +: XLEN]        = mem_pc_q[rd_idx];
          out_dr_d[j*PREG_W +: PREG_W]    = mem_dr_q[rd_idx];
          out_data_d[j*XLEN +: XLEN]      = mem_data_q[rd_idx];
          out_rob_d[j*ROB_W +: ROB_W]     = mem_rob_q[rd_idx];
        end
      end
    end
  end

  // Advance pointers and occupancy; a flush wins over enqueue and dequeue
  always_comb begin
    overflow_d = overflow_q | enq_drop;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(n_deq);
      tail_d  = tail_q + PTR_W'(n_enq);
      count_d = count_q + n_enq - n_deq;
    end
  end

  // Control and output registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= '0;
      out_pc_q    <= '0;
      out_dr_q    <= '0;
      out_data_q  <= '0;
      out_rob_q   <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_dr_q    <= out_dr_d;
      out_data_q  <= out_data_d;
      out_rob_q   <= out_rob_d;
    end
  end

  // Payload storage needs no reset: occupancy decides which slots are live
  always_ff @(posedge clk) begin
    mem_pc_q   <= mem_pc_d;
    mem_dr_q   <= mem_dr_d;
    mem_data_q <= mem_data_d;
    mem_rob_q  <= mem_rob_d;
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_dr       = out_dr_q;
  assign out_data     = out_data_q;
  assign out_rob      = out_rob_q;
  assign count        = count_q;
  assign overflow_err = overflow_q;

endmodule
